// File: rtl/seq_divider_pkg.sv
// Shared divider definitions: FSM state encodings, default width, INT_MIN.
package seq_divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Shift the next dividend bit into the remainder and trial-subtract the divisor
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider: FSM, iteration counter, sign/abs handling, output registers.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   // Magnitudes of the operands; INT_MIN maps to itself and is used as unsigned
   always_comb begin
      abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   assign busy = (state == S_RUN) || (state == S_FIX);

   // Sequencer: a start pulse wins in every state so a restart discards the
   // in-flight operation; the ready strobe is issued one cycle after DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         rem            <= '0;
         quo            <= '0;
         divisor        <= '0;
         sign_q         <= 1'b0;
         sign_r         <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_DIV) begin
            sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r  <= data_operandA[WIDTH-1];
            quo     <= abs_a;
            divisor <= abs_b;
            rem     <= '0;
            cnt     <= '0;
            if (data_operandB == '0) begin
               data_result    <= '0;
               data_remainder <= '0;
               data_exception <= 1'b1;
               state          <= S_DONE;
            end else if (data_operandA == MIN_VAL && data_operandB == '1) begin
               data_result    <= MIN_VAL;
               data_remainder <= '0;
               data_exception <= 1'b1;
               state          <= S_DONE;
            end else begin
               state <= S_RUN;
            end
         end else begin
            case (state)
               S_RUN: begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH-1)) state <= S_FIX;
               end
               S_FIX: begin
                  data_result    <= sign_q ? -quo : quo;
                  data_remainder <= sign_r ? -rem : rem;
                  data_exception <= 1'b0;
                  state          <= S_DONE;
               end
               S_DONE: begin
                  data_resultRDY <= 1'b1;
                  state          <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
